counter_share_scheduler: RTL
============================

Name: counter_share_scheduler

Overview:
Round-robin scheduler that shares one external 4-bit synchronous up-counter datapath between NREQ requesters.
- Each requester asks for a timed run with a terminal value.
- The scheduler grants the counter, clears it, and enables counting up to the owner's terminal value.
- On completion it pulses done to the owner and releases the counter.
- It sits between the requesting control FSMs and the counter's clear/enable inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 4, counter width and terminal-value width

Ports:
clk  input  1  system clock, all state changes on posedge
clear  input  1  synchronous active-high reset
req  input  NREQ  request per requester; level, held until done or abandoned
len  input  NREQ*CW  terminal count per requester; slice i = len[i*CW +: CW]
count  input  CW  current value of the shared counter (registered in counter)
cnt_clear  output  1  synchronous clear to the counter
cnt_en  output  1  count enable to the counter (+1 per clk when high)
grant  output  NREQ  one-hot current owner, 0 when idle
done  output  NREQ  one-cycle pulse on owner's bit at completion
busy  output  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is clear, synchronous and active-high; it is sampled only at posedge clk.
- Reset values: state=IDLE, grant=0, done=0, cnt_clear=0, cnt_en=0, busy=0, round-robin pointer=0. Requester 0 has highest priority after reset.
- Reset mid-operation: clear in any state forces the reset values on the next edge. No done pulse is issued. The counter is not cleared by this block.
- States are IDLE, CLR, RUN, DONE, one-hot encoded.
- IDLE:
  - If req != 0, select the first set bit searching from ptr upward modulo NREQ.
  - Register grant to that one-hot bit and latch tgt = len slice of the winner.
  - Next state CLR.
  - If req == 0, stay in IDLE.
- CLR:
  - cnt_clear=1, cnt_en=0.
  - Next state RUN. Counter reads 0 in the first RUN cycle.
- RUN:
  - cnt_en = (count < tgt), a combinational compare on count.
  - When count >= tgt, cnt_en=0 that cycle and next state is DONE.
  - RUN therefore lasts tgt+1 cycles, and cnt_en is high for exactly tgt cycles.
- DONE:
  - done = grant for one cycle; cnt_en=0, cnt_clear=0.
  - ptr = winner index + 1 mod NREQ.
  - Next state IDLE; grant=0 there.
- Abort: if req[owner]=0 in CLR or RUN, then that cycle cnt_en=0. Next state IDLE, grant=0, no done, ptr advances past the owner. The counter holds its value.
- Latency: req seen in IDLE at cycle t gives done at t+tgt+3. One transaction occupies tgt+4 cycles including the IDLE arbitration cycle.
- Latching:
  - tgt is latched at grant; len changes during a run are ignored.
  - The owner's req is checked only for abort.
  - req high in IDLE is always a new request.
- Invariants:
  - grant is at most one-hot.
  - cnt_clear and cnt_en are never both high.
  - done is a subset of the previous-cycle grant.
- Width: the compare is unsigned CW-bit. tgt = 2^CW-1 is legal, and the counter never wraps under this control.

Test Plan:
1. Reset: clear=1 for 2 cycles with req=1111 -> grant=0000, done=0000, cnt_clear=0, cnt_en=0, busy=0. First grant after release is 0001.
2. Single run: req=0001, len0=3, req seen at t0 -> cnt_clear=1 at t1; cnt_en=1 at t2..t4 (count 0,1,2); cnt_en=0 at t5 (count 3); done=0001 at t6; busy=0 at t7.
3. Zero length: req=0010, len1=0 at t0 -> CLR t1, RUN t2 with cnt_en=0, done=0010 at t3, cnt_en never high.
4. Full contention: req=1111 held, all len=1 -> grants 0001,0010,0100,1000 then 0001 again. Each done is spaced 5 cycles apart, and grant is never multi-hot.
5. Abort: req0 len=10; drop req0 when count=4 -> that cycle cnt_en=0, next cycle IDLE, no done. Pending req1 is granted next with grant=0010.
6. Mid-run reset: clear during RUN of requester 2 with req=0101 pending -> outputs zero next cycle, no done. After clear drops, requester 0 is granted first (ptr reset).

Source files
------------

// File: rtl/counter_share_scheduler.sv
// -----------------------------------------------------------------------------
// counter_share_scheduler
//
// Round-robin owner of one shared CW-bit up-counter. A requester raises its
// req bit with a terminal value on its len slice. The scheduler grants the
// counter, clears it for one cycle, then enables counting until the counter
// reaches the latched terminal value. It then pulses done to the owner and
// releases the counter. Dropping req while owning the counter abandons the
// run: counting stops at once and the counter keeps whatever value it holds.
//
// Ports:
//   clk        system clock, all state changes on posedge
//   clear      synchronous active-high reset
//   req        per-requester request level (NREQ bits)
//   len        per-requester terminal count, slice i = len[i*CW +: CW]
//   count      current value of the shared counter (registered in the counter)
//   cnt_clear  synchronous clear to the counter
//   cnt_en     count enable to the counter (+1 per clk when high)
//   grant      one-hot current owner, zero when idle
//   done       one-cycle pulse on the owner's bit at completion
//   busy       high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module counter_share_scheduler #(
   parameter int NREQ = 4,
   parameter int CW   = 4
) (
   input  logic               clk,
   input  logic               clear,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*CW-1:0] len,
   input  logic [CW-1:0]      count,
   output logic               cnt_clear,
   output logic               cnt_en,
   output logic [NREQ-1:0]    grant,
   output logic [NREQ-1:0]    done,
   output logic               busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // One-hot state encoding.
   localparam logic [3:0] S_IDLE = 4'b0001;
   localparam logic [3:0] S_CLR  = 4'b0010;
   localparam logic [3:0] S_RUN  = 4'b0100;
   localparam logic [3:0] S_DONE = 4'b1000;

   logic [3:0]      r_state;
   logic [NREQ-1:0] r_grant;
   logic [PW-1:0]   r_idx;    // index of the current owner
   logic [PW-1:0]   r_ptr;    // round-robin search start
   logic [CW-1:0]   r_tgt;    // terminal value latched at grant

   logic            w_win_valid;
   logic [PW-1:0]   w_win_idx;
   logic            w_owner_req;
   logic            w_abort;
   logic            w_reached;
   logic [PW-1:0]   w_next_ptr;

   // Round-robin pick: walk from the far end back toward r_ptr so that the
   // last hit written is the first requester at or after r_ptr.
   // NOTE: every combinational output gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_win_valid = 1'b0;
      w_win_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(int'(r_ptr) + k) % NREQ]) begin
            w_win_valid = 1'b1;
            w_win_idx   = PW'((int'(r_ptr) + k) % NREQ);
         end
      end
   end

   assign w_owner_req = |(req & r_grant);
   assign w_abort     = ((r_state == S_CLR) || (r_state == S_RUN)) && !w_owner_req;
   assign w_reached   = (count >= r_tgt);
   assign w_next_ptr  = (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

   // An abandoned run must leave the counter untouched, so the clear is
   // suppressed as well as the enable once the owner drops its request.
   assign cnt_clear = (r_state == S_CLR) && w_owner_req;
   assign cnt_en    = (r_state == S_RUN) && w_owner_req && !w_reached;
   assign grant     = r_grant;
   assign done      = (r_state == S_DONE) ? r_grant : '0;
   assign busy      = (r_state != S_IDLE);

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_tgt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_win_valid) begin
                  r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
                  r_idx   <= w_win_idx;
                  r_tgt   <= len[int'(w_win_idx)*CW +: CW];
                  r_state <= S_CLR;
               end
            end
            S_CLR: begin
               if (w_abort) begin
                  r_grant <= '0;
                  r_ptr   <= w_next_ptr;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_abort) begin
                  r_grant <= '0;
                  r_ptr   <= w_next_ptr;
                  r_state <= S_IDLE;
               end else if (w_reached) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_grant <= '0;
               r_ptr   <= w_next_ptr;
               r_state <= S_IDLE;
            end
            default: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
